// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore control FSM for the multicycle RV32I datapath.
//   clockCPU       in   CPU clock, rising edge
//   reset          in   asynchronous, active-high; also forces every output to 0
//   iOpcode        in   IR[6:0] of the latched instruction
//   oEscreveIR     out  IR load enable
//   oMDRWrite      out  MDR load enable
//   oIouD          out  memory address select (0 PC, 1 ALUOut)
//   oMemWrite      out  memory write enable
//   oEscrevePC     out  unconditional PC write
//   oEscrevePCCond out  PC write qualified by branch condition
//   oEscrevePCBack out  PCBack <= PC
//   oOrigPC        out  PC source (0 ALU result, 1 ALUOut)
//   oOrigAULA      out  ALU A select (00 PCBack, 01 rs1, 10 PC)
//   oOrigBULA      out  ALU B select (00 rs2, 01 const 4, 10 imm)
//   oALUOp         out  00 add, 01 sub/compare, 10 R funct, 11 I funct
//   oMem2Reg       out  write-back source (00 ALUOut, 01 PC, 10 MDR, 11 imm)
//   oEscreveReg    out  register-file write enable
//   estado         out  current state code for the debug display
module controle_multiciclo #(
   parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
   input  logic       clockCPU,
   input  logic       reset,
   input  logic [6:0] iOpcode,
   output logic       oEscreveIR,
   output logic       oMDRWrite,
   output logic       oIouD,
   output logic       oMemWrite,
   output logic       oEscrevePC,
   output logic       oEscrevePCCond,
   output logic       oEscrevePCBack,
   output logic       oOrigPC,
   output logic [1:0] oOrigAULA,
   output logic [1:0] oOrigBULA,
   output logic [1:0] oALUOp,
   output logic [1:0] oMem2Reg,
   output logic       oEscreveReg,
   output logic [3:0] estado
);
   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADDR  = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXEC_R   = 4'd6,
      EXEC_I   = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9,
      JAL      = 4'd10,
      JALR     = 4'd11,
      LUI      = 4'd12,
      ERRO     = 4'd15
   } state_t;

   state_t estado_q, estado_d;

   // The PC reset value lives in the datapath; the parameter is kept only for reference.
   logic unused_pc_reset;
   assign unused_pc_reset = ^PC_RESET;

   assign estado = estado_q;

   always_ff @(posedge clockCPU or posedge reset)
      if (reset) estado_q <= FETCH;
      else       estado_q <= estado_d;

   // While reset is high the decode runs as ERRO, whose outputs are all 0, so the
   // enables drop in the same cycle; estado_d is ignored because the flop is held.
   always_comb begin
      estado_d       = FETCH;
      oEscreveIR     = 1'b0;
      oMDRWrite      = 1'b0;
      oIouD          = 1'b0;
      oMemWrite      = 1'b0;
      oEscrevePC     = 1'b0;
      oEscrevePCCond = 1'b0;
      oEscrevePCBack = 1'b0;
      oOrigPC        = 1'b0;
      oOrigAULA      = 2'b00;
      oOrigBULA      = 2'b00;
      oALUOp         = 2'b00;
      oMem2Reg       = 2'b00;
      oEscreveReg    = 1'b0;
      case (reset ? ERRO : estado_q)
         FETCH: begin
            estado_d       = DECODE;
            oEscreveIR     = 1'b1;
            oEscrevePCBack = 1'b1;
            oOrigAULA      = 2'b10;
            oOrigBULA      = 2'b01;
            oEscrevePC     = 1'b1;
         end
         DECODE: begin
            oOrigBULA = 2'b10;
            case (iOpcode)
               7'b0000011, 7'b0100011: estado_d = MEMADDR;
               7'b0110011:             estado_d = EXEC_R;
               7'b0010011:             estado_d = EXEC_I;
               7'b1100011:             estado_d = BRANCH;
               7'b1101111:             estado_d = JAL;
               7'b1100111:             estado_d = JALR;
               7'b0110111:             estado_d = LUI;
               default:                estado_d = ERRO;
            endcase
         end
         MEMADDR: begin
            estado_d  = (iOpcode == 7'b0000011) ? MEMREAD : MEMWRITE;
            oOrigAULA = 2'b01;
            oOrigBULA = 2'b10;
         end
         MEMREAD: begin
            estado_d  = MEMWB;
            oIouD     = 1'b1;
            oMDRWrite = 1'b1;
         end
         MEMWB: begin
            oMem2Reg    = 2'b10;
            oEscreveReg = 1'b1;
         end
         MEMWRITE: begin
            oIouD     = 1'b1;
            oMemWrite = 1'b1;
         end
         EXEC_R: begin
            estado_d  = ALUWB;
            oOrigAULA = 2'b01;
            oALUOp    = 2'b10;
         end
         EXEC_I: begin
            estado_d  = ALUWB;
            oOrigAULA = 2'b01;
            oOrigBULA = 2'b10;
            oALUOp    = 2'b11;
         end
         ALUWB: oEscreveReg = 1'b1;
         BRANCH: begin
            oOrigAULA      = 2'b01;
            oALUOp         = 2'b01;
            oOrigPC        = 1'b1;
            oEscrevePCCond = 1'b1;
         end
         JAL: begin
            oMem2Reg    = 2'b01;
            oEscreveReg = 1'b1;
            oOrigPC     = 1'b1;
            oEscrevePC  = 1'b1;
         end
         JALR: begin
            oOrigAULA   = 2'b01;
            oOrigBULA   = 2'b10;
            oEscrevePC  = 1'b1;
            oMem2Reg    = 2'b01;
            oEscreveReg = 1'b1;
         end
         LUI: begin
            oMem2Reg    = 2'b11;
            oEscreveReg = 1'b1;
         end
         ERRO: estado_d = ERRO;
         default: estado_d = FETCH;
      endcase
   end
endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Main control unit for the multicycle RV32I processor. A Moore state machine clocked by `clockCPU` sequences each instruction through fetch, decode, execute, memory and write-back. It drives every enable and mux select the multicycle datapath consumes (IR/MDR latches, PC/PCBack writes, IorD address select, memory write, register-file write, ALU operand and operation selects). Its state register is exported as `estado` for the debug display.

## Interface
Parameters:
- `PC_RESET`, 32'h0040_0000, informational only; the datapath owns the PC reset value.

Ports:
- `clockCPU`  in  1  CPU clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `iOpcode`  in  7  `IR[6:0]` of the latched instruction.
- `oEscreveIR`  out  1  IR load enable.
- `oMDRWrite`  out  1  MDR load enable.
- `oIouD`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `oMemWrite`  out  1  memory write enable (the datapath splits it by `address[28]`).
- `oEscrevePC`  out  1  unconditional PC write.
- `oEscrevePCCond`  out  1  PC write qualified by the datapath branch condition.
- `oEscrevePCBack`  out  1  PCBack <= PC.
- `oOrigPC`  out  1  PC source: 0 = ALU result, 1 = ALUOut.
- `oOrigAULA`  out  2  ALU A: 00 PCBack, 01 rs1 (A), 10 PC.
- `oOrigBULA`  out  2  ALU B: 00 rs2 (B), 01 constant 4, 10 immediate.
- `oALUOp`  out  2  00 add, 01 subtract/compare, 10 R-type funct decode, 11 I-type funct decode.
- `oMem2Reg`  out  2  write-back data: 00 ALUOut, 01 PC (link), 10 MDR, 11 immediate.
- `oEscreveReg`  out  1  register-file write enable.
- `estado`  out  4  current state code.

## Operation
Outputs are a pure function of `estado`. Any signal not listed for a state is 0 (selects = 00).

States and outputs:
- FETCH (0): oIouD=0, oEscreveIR, oEscrevePCBack, A=PC, B=4, add, oOrigPC=0, oEscrevePC.
- DECODE (1): A=PCBack, B=imm, add. ALUOut then holds the branch/JAL target.
- MEMADDR (2): A=rs1, B=imm, add.
- MEMREAD (3): oIouD=1, oMDRWrite.
- MEMWB (4): oMem2Reg=10, oEscreveReg.
- MEMWRITE (5): oIouD=1, oMemWrite.
- EXEC_R (6): A=rs1, B=rs2, ALUOp=10.
- EXEC_I (7): A=rs1, B=imm, ALUOp=11.
- ALUWB (8): oMem2Reg=00, oEscreveReg.
- BRANCH (9): A=rs1, B=rs2, ALUOp=01, oOrigPC=1, oEscrevePCCond.
- JAL (10): oMem2Reg=01, oEscreveReg, oOrigPC=1, oEscrevePC.
- JALR (11): A=rs1, B=imm, add, oOrigPC=0, oEscrevePC, oMem2Reg=01, oEscreveReg.
- LUI (12): oMem2Reg=11, oEscreveReg.
- ERRO (15): all outputs 0.

Transitions:
- FETCH -> DECODE.
- DECODE dispatches on `iOpcode`:
  - 0000011 or 0100011 -> MEMADDR.
  - 0110011 -> EXEC_R.
  - 0010011 -> EXEC_I.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - 1100111 -> JALR.
  - 0110111 -> LUI.
  - any other value -> ERRO.
- MEMADDR: opcode 0000011 -> MEMREAD; otherwise -> MEMWRITE.
- MEMREAD -> MEMWB.
- EXEC_R and EXEC_I -> ALUWB.
- MEMWB, MEMWRITE, ALUWB, BRANCH, JAL, JALR, LUI -> FETCH.
- ERRO -> ERRO; only reset leaves it.
- Unused codes 13 and 14 -> FETCH on the next edge, with all outputs 0.

## Timing
- Reset asserted: `estado` = 4'b0000 immediately (asynchronous). All enables are gated to 0 while `reset` is high, so no PC, IR, memory or register write occurs during reset.
- First rising edge after reset deasserts: FETCH executes.
- Cycles per instruction:
  - 5: load.
  - 4: store, R-type, I-type.
  - 3: branch, JAL, JALR, LUI.
- `iOpcode` is sampled only in DECODE and MEMADDR. It is stable there because IR is written only in FETCH.
- JALR: rs1 comes from the A register latched in DECODE, so rd == rs1 links correctly.
- Reset mid-instruction: the instruction is aborted and no partial write completes. Enable outputs drop combinationally, within the same cycle reset asserts.

## Test plan
- Reset held 3 cycles, then released: `estado`=0 and all enables 0 during reset. First edge -> estado=1; oEscreveIR, oEscrevePC and oEscrevePCBack high for exactly the one FETCH cycle.
- iOpcode=0000011: state sequence 0,1,2,3,4,0. oMDRWrite only in state 3; oEscreveReg with oMem2Reg=10 only in state 4.
- iOpcode=0100011: sequence 0,1,2,5,0. oMemWrite=1 and oIouD=1 only in state 5; oEscreveReg never asserted.
- iOpcode=0110011 then 0010011: sequences 0,1,6,8,0 and 0,1,7,8,0, with ALUOp=10 in state 6 and ALUOp=11 in state 7. iOpcode=1100011: sequence 0,1,9,0 with oEscrevePCCond=1 and oOrigPC=1 in state 9.
- iOpcode=1101111, 1100111, 0110111: sequences via states 10, 11, 12 respectively, each 3 cycles. Required signals: JAL oOrigPC=1; JALR oOrigPC=0 with A=01, B=10; LUI oMem2Reg=11.
- iOpcode=1111111: estado goes 1 -> 15 and stays 15 for 10 cycles with all outputs 0. Reset asserted mid-MEMWRITE (state 5): oMemWrite falls in the same cycle, estado=0.
